// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: ALU results always win the single write port, and LSU loads queue and drain on idle cycles.
// The write port is registered, so a write appears one cycle after it wins. LSU backpressure comes from lsu_ready_o, which drops when the queue is full.
module rf_wb_arbiter #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         alu_valid_i,
   input  logic [4:0]                   alu_rd_i,
   input  logic [XLEN-1:0]              alu_data_i,
   input  logic                         lsu_valid_i,
   output logic                         lsu_ready_o,
   input  logic [4:0]                   lsu_rd_i,
   input  logic [XLEN-1:0]              lsu_data_i,
   output logic [4:0]                   WA3_o,
   output logic [XLEN-1:0]              WD3_o,
   output logic                         WE3_o,
   output logic [31:0]                  busy_o,
   output logic [$clog2(DEPTH+1)-1:0]   pending_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [4:0]       ent_rd  [DEPTH];
   logic [XLEN-1:0]  ent_dat [DEPTH];
   logic [DEPTH-1:0] ent_live;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   logic alu_wr;
   logic push;
   logic pop;
   logic head_live;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign alu_wr      = alu_valid_i && (alu_rd_i != 5'd0);
   assign lsu_ready_o = (count < FULL);
   // Loads to x0 complete the handshake but never occupy a slot
   assign push        = lsu_valid_i && lsu_ready_o && (lsu_rd_i != 5'd0);
   assign pop         = !alu_wr && (count != '0);
   assign head_live   = ent_live[rd_ptr];
   assign pending_o   = count;

   // A slot's live bit is cleared when it pops, so live implies occupied
   always_comb begin
      busy_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_live[i]) busy_o[ent_rd[i]] = 1'b1;
      end
      busy_o[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_rd[i]  <= '0;
            ent_dat[i] <= '0;
         end
         ent_live <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         WE3_o    <= 1'b0;
         WA3_o    <= '0;
         WD3_o    <= '0;
      end else begin
         // A younger ALU write to the same register makes queued loads stale
         for (int i = 0; i < DEPTH; i++) begin
            if (alu_wr && (ent_rd[i] == alu_rd_i)) ent_live[i] <= 1'b0;
         end

         if (pop) begin
            ent_live[rd_ptr] <= 1'b0;
            rd_ptr           <= nxt(rd_ptr);
         end

         // A push never lands on the head being popped: push needs a free slot, pop needs a full one
         if (push) begin
            ent_rd[wr_ptr]   <= lsu_rd_i;
            ent_dat[wr_ptr]  <= lsu_data_i;
            ent_live[wr_ptr] <= !(alu_wr && (alu_rd_i == lsu_rd_i));
            wr_ptr           <= nxt(wr_ptr);
         end

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (alu_wr) begin
            WE3_o <= 1'b1;
            WA3_o <= alu_rd_i;
            WD3_o <= alu_data_i;
         end else if (pop && head_live) begin
            WE3_o <= 1'b1;
            WA3_o <= ent_rd[rd_ptr];
            WD3_o <= ent_dat[rd_ptr];
         end else begin
            WE3_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected RF writes go into a scoreboard queue, and a negedge monitor checks every write the DUT emits.
module tb_rf_wb_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        alu_valid_i;
   logic [4:0]  alu_rd_i;
   logic [31:0] alu_data_i;
   logic        lsu_valid_i;
   logic        lsu_ready_o;
   logic [4:0]  lsu_rd_i;
   logic [31:0] lsu_data_i;
   logic [4:0]  WA3_o;
   logic [31:0] WD3_o;
   logic        WE3_o;
   logic [31:0] busy_o;
   logic [1:0]  pending_o;

   int checks   = 0;
   int failures = 0;
   logic [36:0] expq[$];
   logic [36:0] mon_exp;

   always #5 clk_i = ~clk_i;

   rf_wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
      .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
      .WA3_o(WA3_o), .WD3_o(WD3_o), .WE3_o(WE3_o),
      .busy_o(busy_o), .pending_o(pending_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
      lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ld;
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
      expq.push_back({rd, d});
   endtask

   always @(negedge clk_i) begin
      if (rst_ni && WE3_o) begin
         checks++;
         if (expq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: got x%0d=%0h expected no write", WA3_o, WD3_o);
         end else begin
            mon_exp = expq.pop_front();
            if ({WA3_o, WD3_o} !== mon_exp) begin
               failures++;
               $display("FAIL wb_write: got x%0d=%0h expected x%0d=%0h",
                        WA3_o, WD3_o, mon_exp[36:32], mon_exp[31:0]);
            end
         end
      end
   end

   initial begin
      rst_ni = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      #12;
      chk("rst_we", WE3_o, 0);
      chk("rst_wa_wd", {WA3_o, WD3_o}, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_pending", pending_o, 0);
      chk("rst_ready", lsu_ready_o, 1);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      cyc();

      // T2: ALU write appears one cycle later, then the write port holds its address
      drive(1, 5, 32'hDEADBEEF, 0, 0, 0); expect_wr(5, 32'hDEADBEEF); cyc();
      chk("t2_we", WE3_o, 1);
      chk("t2_wa", WA3_o, 5);
      chk("t2_wd", WD3_o, 32'hDEADBEEF);
      drive(0, 0, 0, 0, 0, 0); cyc();
      chk("t2_idle_we", WE3_o, 0);
      chk("t2_hold_wa", WA3_o, 5);

      // T3: load queued behind three ALU cycles
      drive(1, 1, 32'h101, 1, 7, 32'h11); expect_wr(1, 32'h101); cyc();
      chk("t3_busy_a", busy_o, 32'h80);
      chk("t3_pending", pending_o, 1);
      drive(1, 2, 32'h102, 0, 0, 0); expect_wr(2, 32'h102); cyc();
      chk("t3_busy_b", busy_o, 32'h80);
      drive(1, 3, 32'h103, 0, 0, 0); expect_wr(3, 32'h103); cyc();
      chk("t3_busy_c", busy_o, 32'h80);
      drive(0, 0, 0, 0, 0, 0); expect_wr(7, 32'h11); cyc();
      chk("t3_we", WE3_o, 1);
      chk("t3_wa", WA3_o, 7);
      chk("t3_busy_clr", busy_o, 0);
      chk("t3_pending_clr", pending_o, 0);

      // T4: fill, stall a third load, then drain with simultaneous push+pop
      drive(1, 10, 32'hA10, 1, 3, 32'h33); expect_wr(10, 32'hA10); cyc();
      chk("t4_ready_one", lsu_ready_o, 1);
      drive(1, 11, 32'hA11, 1, 4, 32'h44); expect_wr(11, 32'hA11); cyc();
      chk("t4_full_ready", lsu_ready_o, 0);
      chk("t4_full_pending", pending_o, 2);
      drive(1, 12, 32'hA12, 1, 5, 32'h55); expect_wr(12, 32'hA12); cyc();
      chk("t4_stall_busy", busy_o, 32'h18);
      chk("t4_stall_pending", pending_o, 2);
      drive(1, 13, 32'hA13, 1, 5, 32'h55); expect_wr(13, 32'hA13); cyc();
      chk("t4_stall_ready", lsu_ready_o, 0);
      drive(0, 0, 0, 1, 5, 32'h55); expect_wr(3, 32'h33); cyc();
      chk("t4_pop_pending", pending_o, 1);
      chk("t4_pop_busy", busy_o, 32'h10);
      chk("t4_pop_ready", lsu_ready_o, 1);
      drive(0, 0, 0, 1, 5, 32'h55); expect_wr(4, 32'h44); cyc();
      chk("t4_pushpop_pending", pending_o, 1);
      chk("t4_pushpop_busy", busy_o, 32'h20);
      drive(0, 0, 0, 0, 0, 0); expect_wr(5, 32'h55); cyc();
      chk("t4_drained", pending_o, 0);
      cyc();
      chk("t4_empty_we", WE3_o, 0);

      // T5: a younger ALU write kills a queued load
      drive(1, 20, 32'h120, 1, 9, 32'h99); expect_wr(20, 32'h120); cyc();
      chk("t5_busy_set", busy_o, 32'h200);
      drive(1, 9, 32'hA, 0, 0, 0); expect_wr(9, 32'hA); cyc();
      chk("t5_busy_kill", busy_o, 0);
      chk("t5_dead_pending", pending_o, 1);
      drive(0, 0, 0, 0, 0, 0); cyc();
      chk("t5_dead_pop_we", WE3_o, 0);
      chk("t5_dead_pop_pending", pending_o, 0);

      // Same-cycle push and ALU write to the same rd: the ALU wins
      drive(1, 14, 32'hE, 1, 14, 32'hBAD); expect_wr(14, 32'hE); cyc();
      chk("samecyc_busy", busy_o, 0);
      chk("samecyc_pending", pending_o, 1);
      drive(0, 0, 0, 0, 0, 0); cyc();
      chk("samecyc_pop_we", WE3_o, 0);
      chk("samecyc_pop_pending", pending_o, 0);

      // ALU with rd=0 leaves the port free for a drain
      drive(1, 15, 32'h15, 1, 16, 32'h66); expect_wr(15, 32'h15); cyc();
      drive(1, 0, 32'h777, 0, 0, 0); expect_wr(16, 32'h66); cyc();
      chk("rd0_drain_we", WE3_o, 1);
      chk("rd0_drain_wa", WA3_o, 16);
      drive(0, 0, 0, 0, 0, 0); cyc();

      // T6: rd=0 on both sides
      drive(1, 0, 32'h123, 1, 0, 32'h456);
      #1;
      chk("t6_ready", lsu_ready_o, 1);
      cyc();
      chk("t6_we", WE3_o, 0);
      chk("t6_pending", pending_o, 0);
      chk("t6_busy", busy_o, 0);
      drive(0, 0, 0, 0, 0, 0); cyc();

      // T1: reset mid-traffic discards the queue
      drive(1, 17, 32'h17, 1, 18, 32'h18); expect_wr(17, 32'h17); cyc();
      drive(1, 19, 32'h19, 1, 21, 32'h21); expect_wr(19, 32'h19); cyc();
      chk("t1_pending_full", pending_o, 2);
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk_i); #1;
      rst_ni = 1'b0;
      #1;
      chk("t1_we", WE3_o, 0);
      chk("t1_busy", busy_o, 0);
      chk("t1_pending", pending_o, 0);
      chk("t1_wa", WA3_o, 0);
      cyc(); cyc();
      rst_ni = 1'b1;
      cyc(); cyc(); cyc();
      chk("t1_post_we", WE3_o, 0);
      chk("t1_post_pending", pending_o, 0);

      chk("scoreboard_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
